// File: rtl/bram_stream_reader_pkg.sv
// Shared types and defaults for the block-RAM stream reader.
// The FIFO entry pairs one RAM word with its end-of-burst tag.
package bram_stream_reader_pkg;

  localparam int DATA_W    = 512;
  localparam int ADDR_W    = 15;
  localparam int RAM_DEPTH = 20480;
  localparam int FIFO_D    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } fifo_entry_t;

endpackage

// File: rtl/bram_stream_fifo.sv
// Small synchronous FIFO holding read words until the sink takes them.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module bram_stream_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_empty     = (r_count == {CW{1'b0}});
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_count     = r_count;

endmodule

// File: rtl/bram_stream_reader.sv
// Burst reader for one block-RAM port: issues reads under FIFO credit and
// streams the returned words on a valid/ready interface with a last marker.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DEPTH      = RAM_DEPTH,
  parameter int FIFO_DEPTH = FIFO_D
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_size,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = CW + 1;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic                  r_inflight;
  logic                  r_last_tag;

  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_pop;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [CW-1:0]         w_count;
  logic [CRW-1:0]        w_credit;
  logic                  w_empty;
  logic                  w_full;
  fifo_entry_t           w_push_entry;
  fifo_entry_t           w_head;

  assign w_pop        = out_valid & out_ready;
  assign w_accept     = (r_state == ST_IDLE) & req_valid;
  assign w_last_issue = (r_remaining == {ADDR_WIDTH{1'b0}});

  // A slot is free when words held plus words on the way, less the word
  // leaving this cycle, stay below the FIFO size.
  assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_issue  = (r_state == ST_READ) & (w_credit < CRW'(FIFO_DEPTH));

  assign w_addr_next = (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? {ADDR_WIDTH{1'b0}}
                                                          : r_addr + ADDR_WIDTH'(1);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; leaving DRAIN coincides with popping the last word.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next_state = ST_READ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ: begin
        if (w_issue && w_last_issue) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_READ;
        end
      end
      ST_DRAIN: begin
        if ((w_pop && w_head.last) || (w_empty && !r_inflight)) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Burst address/count tracking and the one-cycle read-return pipeline.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_remaining <= {ADDR_WIDTH{1'b0}};
      r_inflight  <= 1'b0;
      r_last_tag  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_last_tag <= w_issue & w_last_issue;
      if (w_accept) begin
        r_addr      <= req_addr;
        r_remaining <= req_size;
      end else if (w_issue) begin
        r_addr      <= w_addr_next;
        r_remaining <= r_remaining - ADDR_WIDTH'(1);
      end
    end
  end

  assign w_push_entry.data = mem_dout;
  assign w_push_entry.last = r_last_tag;

  bram_stream_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_push      (r_inflight),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_count     (w_count)
  );

  // Returning data must always find room; credit issue makes this hold.
  always_ff @(posedge clock) begin
    if (reset_n && r_inflight && !w_pop) begin
      assert (!w_full);
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign mem_en    = w_issue;
  assign mem_addr  = r_addr;
  assign out_valid = ~w_empty;
  assign out_data  = w_head.data;
  assign out_last  = w_head.last & ~w_empty;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench: stimulus announces each accepted burst, a negedge monitor
// owns the expected-word and expected-address queues and compares outputs.
module tb_bram_stream_reader;

  localparam int DEPTH = 20480;
  localparam int FDEP  = 2;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [14:0]  req_addr;
  logic [14:0]  req_size;
  logic         mem_en;
  logic [14:0]  mem_addr;
  logic [511:0] mem_dout = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [511:0] out_data;
  logic         out_last;
  logic         busy;

  bram_stream_reader dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [511:0] ram_word(input int a);
    logic [511:0] w;
    for (int l = 0; l < 16; l++) begin
      w[l*32 +: 32] = {a[14:0], 17'(l)} ^ 32'h5A3C_96E1;
    end
    return w;
  endfunction

  // RAM model: one-cycle read latency.
  always @(posedge clock) begin
    if (mem_en) mem_dout <= ram_word(int'(mem_addr));
  end

  // Stimulus-owned handshake with the monitor.
  int acc_cnt   = 0;
  int acc_addr  = 0;
  int acc_size  = 0;
  bit rand_mode = 1'b0;

  // Monitor-owned scoreboard state.
  int          total = 0;
  int          bad   = 0;
  logic [512:0] exp_q[$];
  int          addr_q[$];
  int          seen_cnt = 0;
  bit          in_burst = 1'b0;
  bit          clr_next = 1'b0;
  bit          prev_stall = 1'b0;
  logic [511:0] prev_data;
  logic        prev_last;
  int          issued = 0;
  int          popped = 0;
  int          pop_total = 0;
  int          cyc = 0;
  bit          pat_on = 1'b0;
  int          pat_size = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clock) begin
    logic [512:0] e;
    int ea;
    if (!reset_n) begin
      exp_q.delete();
      addr_q.delete();
      seen_cnt   = acc_cnt;
      in_burst   = 1'b0;
      clr_next   = 1'b0;
      prev_stall = 1'b0;
      pat_on     = 1'b0;
      issued     = 0;
      popped     = 0;
      check("rst_req_ready", req_ready, 1);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
    end else begin
      if (clr_next) begin
        in_burst = 1'b0;
        clr_next = 1'b0;
      end
      if (acc_cnt != seen_cnt) begin
        seen_cnt = acc_cnt;
        for (int i = 0; i <= acc_size; i++) begin
          ea = (acc_addr + i) % DEPTH;
          exp_q.push_back({ram_word(ea), (i == acc_size) ? 1'b1 : 1'b0});
          addr_q.push_back(ea);
        end
        in_burst = 1'b1;
        cyc      = 0;
        pat_on   = !rand_mode;
        pat_size = acc_size;
      end else begin
        cyc++;
      end
      check("busy", busy, in_burst);
      check("req_ready", req_ready, !in_burst);
      if (pat_on && cyc <= pat_size + 3) begin
        check("rate_mem_en", mem_en, (cyc <= pat_size) ? 1 : 0);
        check("rate_out_valid", out_valid, (cyc >= 2 && cyc <= pat_size + 2) ? 1 : 0);
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (mem_en) begin
        check("outstanding_ok", (issued - popped + 1 - int'(out_valid & out_ready)) <= FDEP, 1);
        if (addr_q.size() == 0) begin
          check("unexpected_read", 1, 0);
        end else begin
          ea = addr_q.pop_front();
          check("mem_addr", mem_addr, ea);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[512:1]);
          check("out_last", out_last, e[0]);
        end
        pop_total++;
        if (out_last) clr_next = 1'b1;
      end
      issued     += int'(mem_en);
      popped     += int'(out_valid & out_ready);
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic do_req(input int a, input int s);
    bit ok = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b1;
    req_addr  = 15'(a);
    req_size  = 15'(s);
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clock);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) begin
      $display("FAIL req_accept_timeout: addr %0d not accepted", a);
      $fatal(1);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    acc_addr  = a;
    acc_size  = s;
    acc_cnt++;
  endtask

  task automatic wait_idle(input int lim);
    bit done = 1'b0;
    for (int k = 0; k < lim && !done; k++) begin
      @(negedge clock); #1;
      if (!in_burst && !busy && exp_q.size() == 0 && acc_cnt == seen_cnt) done = 1'b1;
    end
    if (!done) begin
      $display("FAIL idle_timeout: busy %0b pending %0d", busy, exp_q.size());
      $fatal(1);
    end
  endtask

  initial begin
    int base;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    do_req(5, 0);        wait_idle(50);
    do_req(100, 7);      wait_idle(50);
    rand_mode = 1'b1;
    do_req(0, 9);        wait_idle(400);
    rand_mode = 1'b0;
    do_req(20478, 3);    wait_idle(50);
    do_req(200, 5);
    do_req(300, 1);      wait_idle(50);

    do_req(0, 7);
    base = pop_total;
    for (int k = 0; k < 50 && pop_total < base + 3; k++) @(negedge clock);
    @(posedge clock); #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    do_req(50, 3);       wait_idle(50);

    do_req(0, DEPTH - 1); wait_idle(DEPTH + 100);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
